event_readout: RTL and testbench
================================

Name: event_readout

Overview:
- Parametrised successor to the fixed 32-tube trigger/readout logic.
- On a scintillator coincidence, opens an acquisition window and records a first-hit time per drift-tube channel.
- Then serialises header, per-channel data and trailer words into the downstream 16-bit FIFO, honouring `fifo_full` backpressure.
- Also adds zero suppression, an event counter and dropped-trigger reporting.
- Sits between the tube input pins and the FIFO that feeds the RPi.

Parameters:
- N_CH, 32: number of tube channels; 1..254.
- WINDOW, 250: acquisition window length in clk100 cycles; 1..253.
- DEAD_CYC, 11: clear/dead-time cycles after the trailer; must be at least 1.

Ports:
- clk100  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  coincidence trigger (SCIN_COIN); already synchronised to clk100; level.
- tube_in  in  N_CH  tube discriminator inputs; already synchronised; bit i is channel i.
- zs_en  in  1  zero-suppression enable; sampled on entry to READOUT.
- fifo_din  out  16  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full.
- busy  out  1  high in every state except IDLE.
- evt_dropped  out  1  one-cycle pulse per trigger rejected while busy.
- evt_count  out  8  number of accepted events; wraps.

Behaviour:
- Reset values: state IDLE; all outputs 0; all hit times 0.
- Reset applied mid-event abandons the partial event; no trailer is written.
- States and transitions:
  - IDLE: go to ACQ when trig=1.
  - ACQ: lasts exactly WINDOW cycles, then READOUT.
  - READOUT: emits header, channel words, trailer; then CLEAR.
  - CLEAR: lasts DEAD_CYC cycles, then IDLE.
- IDLE→ACQ: on the same edge, evt_count increments (255 wraps to 0) and the window counter loads 1.
- ACQ timing:
  - Window counter runs 1..WINDOW, one value per cycle.
  - Channel i captures time = current counter value on the first ACQ cycle where tube_in[i]=1 and its stored time is 0.
  - Later hits on that channel are ignored.
  - A channel already high on the first ACQ cycle records time 1.
  - A channel with no hit keeps time 0.
- Word formats:
  - Header: {8'hFE, evt_count}, carrying the post-increment value.
  - Data: {time[7:0], chan_id[7:0]}, with chan_id = i.
  - Trailer: 16'hFFFF.
  - The time byte is always ≤ 253, so words are unambiguous.
- READOUT order: header; channels 0..N_CH-1 ascending; trailer.
  - With zs_en=1, channels with time 0 produce no word and cost zero cycles.
  - Skipping must not insert idle cycles; a combinational search for the next hit channel is acceptable.
- Write handshake:
  - fifo_wr_en=1 with fifo_din valid only in a cycle where fifo_full=0.
  - If fifo_full=1, fifo_wr_en=0, the pending word is held and the sequencer does not advance.
  - No word is ever lost or duplicated.
  - fifo_din holds its last value when not writing.
- Throughput: one word per cycle while not full.
  - Unstalled, zs_en=0 event: ACQ WINDOW cycles, READOUT N_CH+2 cycles, CLEAR DEAD_CYC cycles.
- CLEAR: all hit times zeroed on the first CLEAR cycle; tube_in is ignored.
- Triggers while busy:
  - A rising edge of trig (trig=1, previous cycle 0) while busy=1 gives one evt_dropped pulse; the event is not queued.
  - A trig level still high on return to IDLE starts a new event. This matches the existing re-arm behaviour.
- busy rises the cycle after trig is accepted and falls on return to IDLE.

Decomposition:
- Shared package event_pkg holds:
  - state enum (IDLE, ACQ, READOUT, CLEAR);
  - HDR_TAG=8'hFE and TRAILER=16'hFFFF;
  - function build_data_word(time, chan).
- One sub-module, channel_tdc: one per channel. Holds an 8-bit first-hit register; inputs clk100, rst, clr, arm, hit, window count; output time.
- The top level holds the FSM, window/dead counters, readout index and the zero-suppression search.

Test Plan:
- N_CH=4, WINDOW=10, zs_en=0; trig pulse; tube_in[2] high at ACQ cycle 3, tube_in[0] high at cycles 5–9 → FIFO gets FE01, 0500, 0001, 0302, 0003, FFFF; busy low after 1+10+6+11 cycles.
- Same hits with zs_en=1 → FE02, 0500, 0302, FFFF; READOUT lasts exactly 4 cycles.
- fifo_full held high for 3 cycles after the header is written → no wr_en during the stall; the word sequence is identical to the unstalled case.
- trig pulses again during ACQ and during CLEAR → exactly 2 evt_dropped pulses; evt_count unchanged; the next accepted trig gives header FE02.
- rst asserted mid-READOUT → outputs 0 immediately; evt_count 0; no trailer; the next event's header is FE01.
- 256 accepted events → evt_count wraps; the 256th header is FE00.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and constants for the event readout block.
//   state_e         : readout sequencer states
//   HDR_TAG/TRAILER : framing constants for the FIFO word stream
//   build_data_word : packs a channel's first-hit time and channel id into one word
package event_pkg;

    typedef enum logic [1:0] {StIdle, StAcq, StReadout, StClear} state_e;

    localparam logic [7:0]  HDR_TAG = 8'hFE;
    localparam logic [15:0] TRAILER = 16'hFFFF;

    function automatic logic [15:0] build_data_word(input logic [7:0] hit_time,
                                                    input logic [7:0] chan);
        return {hit_time, chan};
    endfunction

endpackage

// File: rtl/event_readout_if.sv
// FIFO write-side bundle between the readout sequencer and the downstream FIFO.
//   fifo_din   : write data
//   fifo_wr_en : write strobe, only asserted while fifo_full is low
//   fifo_full  : FIFO full flag (backpressure)
interface event_readout_if;

    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    modport master (output fifo_din, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_din, input fifo_wr_en, output fifo_full);

endinterface

// File: rtl/channel_tdc.sv
// First-hit time capture for one drift-tube channel.
//   clk100   : system clock
//   rst      : asynchronous active-high reset
//   clr      : zero the stored time
//   arm      : capture enabled (acquisition window open)
//   hit      : tube discriminator input
//   win_cnt  : current window count, stored on the first hit
//   hit_time : stored first-hit time, 0 means no hit
module channel_tdc (
    input  logic       clk100,
    input  logic       rst,
    input  logic       clr,
    input  logic       arm,
    input  logic       hit,
    input  logic [7:0] win_cnt,
    output logic [7:0] hit_time
);

    logic [7:0] time_q;

    // A nonzero time marks the channel as already hit; later hits are ignored.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            time_q <= '0;
        end else if (clr) begin
            time_q <= '0;
        end else if (arm && hit && (time_q == 8'd0)) begin
            time_q <= win_cnt;
        end
    end

    assign hit_time = time_q;

endmodule

// File: rtl/event_readout.sv
// Trigger/readout controller: on a coincidence trigger it opens an acquisition
// window, records first-hit times per tube, then streams header, channel words
// and trailer into the FIFO, honouring backpressure, followed by a dead time.
//   clk100, rst  : clock, asynchronous active-high reset
//   trig         : coincidence trigger level (synchronised)
//   tube_in      : tube discriminator inputs (synchronised)
//   zs_en        : zero suppression, sampled on entry to readout
//   fifo         : FIFO write bundle (master side)
//   busy         : high whenever not idle
//   evt_dropped  : one-cycle pulse per trigger edge rejected while busy
//   evt_count    : accepted-event counter, wraps
module event_readout
    import event_pkg::*;
#(
    parameter int unsigned N_CH     = 32,
    parameter int unsigned WINDOW   = 250,
    parameter int unsigned DEAD_CYC = 11
) (
    input  logic            clk100,
    input  logic            rst,
    input  logic            trig,
    input  logic [N_CH-1:0] tube_in,
    input  logic            zs_en,
    event_readout_if.master fifo,
    output logic            busy,
    output logic            evt_dropped,
    output logic [7:0]      evt_count
);

    // Readout positions: 0 header, 1..N_CH channel (pos-1), N_CH+1 trailer.
    localparam int unsigned PW      = 9;
    localparam int unsigned DW      = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [PW-1:0] TRL_POS = PW'(N_CH + 1);

    state_e          state_q, state_d;
    logic [7:0]      win_q;
    logic [DW-1:0]   dead_q;
    logic [PW-1:0]   ro_idx_q;
    logic [PW-1:0]   cur_pos;
    logic [15:0]     cur_word;
    logic [15:0]     din_q;
    logic [7:0]      evt_count_q;
    logic            zs_q;
    logic            trig_q;
    logic            dropped_q;
    logic            wr_go;
    logic            clr;
    logic            arm;
    logic [7:0]      hit_times [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        channel_tdc u_tdc (
            .clk100   (clk100),
            .rst      (rst),
            .clr      (clr),
            .arm      (arm),
            .hit      (tube_in[g]),
            .win_cnt  (win_q),
            .hit_time (hit_times[g])
        );
    end

    // FSM state register
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (trig) state_d = StAcq;
            StAcq:     if (win_q == 8'(WINDOW)) state_d = StReadout;
            StReadout: if (wr_go && (cur_pos == TRL_POS)) state_d = StClear;
            StClear:   if (dead_q == DW'(DEAD_CYC)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs; the write strobe is combinational so it never fires into a full FIFO.
    always_comb begin
        busy            = (state_q != StIdle);
        arm             = (state_q == StAcq);
        clr             = (state_q == StClear);
        wr_go           = (state_q == StReadout) && !fifo.fifo_full;
        fifo.fifo_wr_en = wr_go;
        fifo.fifo_din   = wr_go ? cur_word : din_q;
    end

    // Next word to emit, searched from ro_idx_q so suppressed channels cost no cycles.
    always_comb begin
        cur_pos = TRL_POS;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if ((PW'(i + 1) >= ro_idx_q) && (!zs_q || (hit_times[i] != 8'd0))) begin
                cur_pos = PW'(i + 1);
            end
        end
        if (ro_idx_q == '0) begin
            cur_pos = '0;
        end
    end

    always_comb begin
        cur_word = TRAILER;
        if (cur_pos == '0) begin
            cur_word = {HDR_TAG, evt_count_q};
        end
        for (int i = 0; i < N_CH; i++) begin
            if (cur_pos == PW'(i + 1)) begin
                cur_word = build_data_word(hit_times[i], 8'(i));
            end
        end
    end

    // Counters and datapath registers
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            win_q       <= 8'd1;
            dead_q      <= DW'(1);
            ro_idx_q    <= '0;
            din_q       <= '0;
            evt_count_q <= '0;
            zs_q        <= 1'b0;
            trig_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            win_q     <= (state_q == StAcq) ? win_q + 8'd1 : 8'd1;
            dead_q    <= (state_q == StClear) ? dead_q + DW'(1) : DW'(1);
            din_q     <= fifo.fifo_din;
            trig_q    <= trig;
            dropped_q <= trig && !trig_q && busy;
            if (state_q != StReadout) begin
                ro_idx_q <= '0;
            end else if (wr_go) begin
                ro_idx_q <= cur_pos + PW'(1);
            end
            if ((state_q == StIdle) && trig) begin
                evt_count_q <= evt_count_q + 8'd1;
            end
            if ((state_q == StAcq) && (state_d == StReadout)) begin
                zs_q <= zs_en;
            end
        end
    end

    assign evt_dropped = dropped_q;
    assign evt_count   = evt_count_q;

endmodule

// File: tb/tb_event_readout.sv
module tb_event_readout;
    localparam int N = 4;
    localparam int W = 10;
    localparam int D = 11;

    logic         clk100 = 1'b0;
    logic         rst;
    logic         trig;
    logic [N-1:0] tube_in;
    logic         zs_en;
    logic         busy;
    logic         evt_dropped;
    logic [7:0]   evt_count;

    event_readout_if fif ();

    event_readout #(.N_CH(N), .WINDOW(W), .DEAD_CYC(D)) dut (
        .clk100      (clk100),
        .rst         (rst),
        .trig        (trig),
        .tube_in     (tube_in),
        .zs_en       (zs_en),
        .fifo        (fif.master),
        .busy        (busy),
        .evt_dropped (evt_dropped),
        .evt_count   (evt_count)
    );

    always #5 clk100 = ~clk100;

    int errors = 0;
    int checks = 0;

    // Monitor: captures FIFO writes and protocol violations.
    logic [15:0] got_mem [0:4095];
    int          got_n = 0;
    int          hs_viol = 0;
    int          hold_viol = 0;
    int          drop_n = 0;
    logic [15:0] last_din = '0;

    always @(posedge clk100 or posedge rst) begin
        if (rst) begin
            last_din <= '0;
        end else begin
            if (fif.fifo_wr_en === 1'b1) begin
                if (got_n < 4096) got_mem[got_n] <= fif.fifo_din;
                got_n    <= got_n + 1;
                last_din <= fif.fifo_din;
                if (fif.fifo_full === 1'b1) hs_viol <= hs_viol + 1;
            end else if (fif.fifo_din !== last_din) begin
                hold_viol <= hold_viol + 1;
            end
            if (evt_dropped === 1'b1) drop_n <= drop_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    logic [N-1:0] pat [1:W];
    logic [7:0]   model_cnt = '0;
    logic [15:0]  last_hdr;

    // Runs one event; mode 0 no stall, 1 random stall, 2 three-cycle stall after header.
    task automatic run_event(input bit rnd, input bit zs, input int mode, input bit drops,
                             output int busy_cycles);
        int          base;
        int          guard;
        int          held;
        bit          clr_done;
        logic [7:0]  t [N];
        logic [15:0] exp_q [$];
        if (rnd) begin
            for (int c = 1; c <= W; c++) pat[c] = N'($urandom & $urandom);
        end
        // Reference: first window cycle (1-based) each channel is seen high.
        for (int i = 0; i < N; i++) begin
            t[i] = 8'd0;
            for (int c = W; c >= 1; c--) if (pat[c][i]) t[i] = 8'(c);
        end
        model_cnt = model_cnt + 8'd1;
        exp_q.push_back({8'hFE, model_cnt});
        for (int i = 0; i < N; i++) begin
            if (!zs || t[i] != 8'd0) exp_q.push_back({t[i], 8'(i)});
        end
        exp_q.push_back(16'hFFFF);

        base  = got_n;
        trig  = 1'b1;
        zs_en = zs;
        step();
        trig = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        busy_cycles = 0;
        for (int c = 1; c <= W; c++) begin
            tube_in = pat[c];
            if (drops) trig = (c == 4);
            if (busy === 1'b1) busy_cycles++;
            step();
        end
        trig = 1'b0;
        guard = 0;
        held = 0;
        clr_done = 0;
        while (busy === 1'b1 && guard < 400) begin
            if (mode == 1) begin
                fif.fifo_full = 1'($urandom_range(0, 1));
            end else if (mode == 2 && got_n == base + 1 && held < 3) begin
                fif.fifo_full = 1'b1;
                held++;
            end else begin
                fif.fifo_full = 1'b0;
            end
            if (drops && !clr_done && got_n > base && got_mem[got_n-1] == 16'hFFFF) begin
                trig = 1'b1;
                clr_done = 1;
            end else begin
                trig = 1'b0;
            end
            tube_in = N'($urandom);
            busy_cycles++;
            guard++;
            step();
        end
        fif.fifo_full = 1'b0;
        trig = 1'b0;
        tube_in = '0;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("evt_count", {24'd0, evt_count}, {24'd0, model_cnt});
        check("word_count", got_n - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_n - base; k++) begin
            check("word", {16'd0, got_mem[base+k]}, {16'd0, exp_q[k]});
        end
        last_hdr = got_mem[base];
    endtask

    initial begin
        int bc;
        int base;
        int guard;
        int d0;
        rst = 1'b1;
        trig = 1'b0;
        tube_in = '0;
        zs_en = 1'b0;
        fif.fifo_full = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {31'd0, fif.fifo_wr_en}, 32'd0);
        check("rst_din", {16'd0, fif.fifo_din}, 32'd0);
        check("rst_count", {24'd0, evt_count}, 32'd0);
        check("rst_dropped", {31'd0, evt_dropped}, 32'd0);
        rst = 1'b0;
        step();

        // Directed hits: ch2 at cycle 3, ch0 at cycles 5..9.
        for (int c = 1; c <= W; c++) pat[c] = '0;
        pat[3] = 4'b0100;
        for (int c = 5; c <= 9; c++) pat[c] = pat[c] | 4'b0001;
        run_event(0, 0, 0, 0, bc);
        check("hdr1", {16'd0, last_hdr}, 32'h0000FE01);
        check("busy_len_nozs", bc, W + N + 2 + D);
        step();
        run_event(0, 1, 0, 0, bc);
        check("busy_len_zs", bc, W + 4 + D);
        step();
        run_event(0, 0, 2, 0, bc);
        check("busy_len_stall", bc, W + N + 2 + D + 3);
        step();

        // Triggers during ACQ and CLEAR are dropped, not queued.
        d0 = drop_n;
        run_event(1, 0, 0, 1, bc);
        step();
        check("drop_pulses", drop_n - d0, 2);
        run_event(1, 1, 1, 0, bc);
        step();

        for (int k = 0; k < 6; k++) begin
            run_event(1, 1'($urandom_range(0, 1)), 1, 0, bc);
            step();
        end

        // Reset mid-readout: partial event abandoned, no trailer.
        base = got_n;
        trig = 1'b1;
        step();
        trig = 1'b0;
        guard = 0;
        while (got_n == base && guard < 100) begin
            guard++;
            step();
        end
        check("pre_rst_hdr_seen", got_n - base, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_wr_en", {31'd0, fif.fifo_wr_en}, 32'd0);
        check("midrst_din", {16'd0, fif.fifo_din}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", {24'd0, evt_count}, 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("midrst_no_more_words", got_n - base, 1);
        model_cnt = 8'd0;
        run_event(1, 0, 0, 0, bc);
        check("hdr_after_rst", {16'd0, last_hdr}, 32'h0000FE01);
        step();

        // 255 further events bring the counter back round to zero.
        for (int k = 0; k < 255; k++) begin
            run_event(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, bc);
        end
        check("wrap_hdr", {16'd0, last_hdr}, 32'h0000FE00);
        check("wrap_count", {24'd0, evt_count}, 32'd0);

        check("no_write_when_full", hs_viol, 0);
        check("din_hold", hold_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
